// File: rtl/pwm_rgb_pkg.sv
// Shared types and lookups for the RGB hue-wheel fade: phase encoding,
// moving-channel/direction table and phase sequencing.
package pwm_rgb_pkg;

   localparam int DUTY_W_DEF = 10;

   typedef enum logic [2:0] {
      PH_RY = 3'd0,
      PH_YG = 3'd1,
      PH_GC = 3'd2,
      PH_CB = 3'd3,
      PH_BM = 3'd4,
      PH_MR = 3'd5
   } phase_t;

   typedef enum logic [1:0] {
      CH_R = 2'd0,
      CH_G = 2'd1,
      CH_B = 2'd2
   } chan_t;

   function automatic phase_t next_phase(input phase_t p);
      case (p)
         PH_RY:   return PH_YG;
         PH_YG:   return PH_GC;
         PH_GC:   return PH_CB;
         PH_CB:   return PH_BM;
         PH_BM:   return PH_MR;
         default: return PH_RY;
      endcase
   endfunction

   function automatic chan_t phase_chan(input phase_t p);
      case (p)
         PH_YG, PH_BM: return CH_R;
         PH_RY, PH_CB: return CH_G;
         default:      return CH_B;
      endcase
   endfunction

   // 1 = moving channel ramps toward full-on, 0 = toward off
   function automatic logic phase_up(input phase_t p);
      return (p == PH_RY) || (p == PH_GC) || (p == PH_BM);
   endfunction

endpackage

// File: rtl/rgb_fade_sched_if.sv
// Control/duty bundle between the fade scheduler and its surroundings
// (run/step/period_end in, committed duties and status out).
interface rgb_fade_sched_if
   import pwm_rgb_pkg::*;
#(
   parameter int DUTY_W = DUTY_W_DEF
);
   logic              run;
   logic [3:0]        step;
   logic              period_end;
   logic [DUTY_W-1:0] duty_r;
   logic [DUTY_W-1:0] duty_g;
   logic [DUTY_W-1:0] duty_b;
   logic [2:0]        phase;
   logic              upd;
   logic              overrun;

   modport master (
      output run, step, period_end,
      input  duty_r, duty_g, duty_b, phase, upd, overrun
   );

   modport slave (
      input  run, step, period_end,
      output duty_r, duty_g, duty_b, phase, upd, overrun
   );
endinterface

// File: rtl/step_prescaler.sv
// Free-running divider producing a one-cycle tick every CLK_FRE/STEP_HZ
// enabled cycles; the count freezes while en is low.
module step_prescaler #(
   parameter int CLK_FRE = 50_000_000,
   parameter int STEP_HZ = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int DIV   = CLK_FRE / STEP_HZ;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   if (DIV < 2) begin : g_div_chk
      $error("step_prescaler: CLK_FRE/STEP_HZ must be at least 2");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = en && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/rgb_fade_sched.sv
// Hue-wheel duty scheduler: step ticks arm a pending update that is
// committed only on a PWM period boundary.
//
//  phase | meaning
//  PH_RY | red->yellow,   green ramps up
//  PH_YG | yellow->green, red ramps down
//  PH_GC | green->cyan,   blue ramps up
//  PH_CB | cyan->blue,    green ramps down
//  PH_BM | blue->magenta, red ramps up
//  PH_MR | magenta->red,  blue ramps down
module rgb_fade_sched
   import pwm_rgb_pkg::*;
#(
   parameter int CLK_FRE  = 50_000_000,
   parameter int STEP_HZ  = 100,
   parameter int DUTY_W   = DUTY_W_DEF,
   parameter int DUTY_MAX = 99
) (
   input  logic             clk,
   input  logic             rst,
   rgb_fade_sched_if.slave  bus
);
   if (DUTY_MAX >= (1 << DUTY_W) || DUTY_W < 4) begin : g_duty_chk
      $error("rgb_fade_sched: DUTY_MAX must fit in DUTY_W bits (DUTY_W >= 4)");
   end

   localparam logic [DUTY_W-1:0] DMAX   = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W:0]   DMAX_X = (DUTY_W+1)'(DUTY_MAX);

   logic tick;

   step_prescaler #(
      .CLK_FRE (CLK_FRE),
      .STEP_HZ (STEP_HZ)
   ) u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.run),
      .tick (tick)
   );

   phase_t            phase_q, phase_d;
   logic [DUTY_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic              pending_q, pending_d;
   logic              upd_q, upd_d;
   logic              overrun_q, overrun_d;

   chan_t             ch;
   logic              up;
   logic              commit;
   logic              at_end;
   logic [DUTY_W-1:0] cur, nxt;
   logic [DUTY_W:0]   s_x, sum_x;

   always_comb begin
      ch     = phase_chan(phase_q);
      up     = phase_up(phase_q);
      s_x    = (bus.step == 4'd0) ? (DUTY_W+1)'(1) : (DUTY_W+1)'(bus.step);
      commit = bus.run && bus.period_end && (pending_q || tick);

      case (ch)
         CH_R:    cur = r_q;
         CH_G:    cur = g_q;
         default: cur = b_q;
      endcase

      // extra bit on the sum so a large step near DUTY_MAX cannot wrap
      sum_x = {1'b0, cur} + s_x;
      if (up) begin
         nxt    = (sum_x > DMAX_X) ? DMAX : sum_x[DUTY_W-1:0];
         at_end = (nxt == DMAX);
      end else begin
         nxt    = ({1'b0, cur} <= s_x) ? '0 : cur - s_x[DUTY_W-1:0];
         at_end = (nxt == '0);
      end

      phase_d   = phase_q;
      r_d       = r_q;
      g_d       = g_q;
      b_d       = b_q;
      pending_d = pending_q;
      upd_d     = 1'b0;
      overrun_d = 1'b0;

      if (!bus.run)         pending_d = 1'b0;
      else if (commit)      pending_d = 1'b0;
      else if (tick)        pending_d = 1'b1;

      // a second tick with no boundary in between is dropped, not queued
      overrun_d = tick && pending_q && !commit;

      if (commit) begin
         upd_d = 1'b1;
         case (ch)
            CH_R:    r_d = nxt;
            CH_G:    g_d = nxt;
            default: b_d = nxt;
         endcase
         if (at_end) phase_d = next_phase(phase_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q   <= PH_RY;
         r_q       <= DMAX;
         g_q       <= '0;
         b_q       <= '0;
         pending_q <= 1'b0;
         upd_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
         pending_q <= pending_d;
         upd_q     <= upd_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.duty_r  = r_q;
   assign bus.duty_g  = g_q;
   assign bus.duty_b  = b_q;
   assign bus.phase   = phase_q;
   assign bus.upd     = upd_q;
   assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_rgb_fade_sched.sv
// Directed bench for rgb_fade_sched at CLK_FRE=1000, STEP_HZ=100 (10-cycle tick).
module tb_rgb_fade_sched;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rgb_fade_sched_if #(.DUTY_W(10)) bus();

   rgb_fade_sched #(
      .CLK_FRE  (1000),
      .STEP_HZ  (100),
      .DUTY_W   (10),
      .DUTY_MAX (99)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int viol     = 0;
   int ov_cnt   = 0;
   int upd_cnt  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int non_end(input logic [9:0] d);
      return (d != 10'd0 && d != 10'd99) ? 1 : 0;
   endfunction

   // one clock with the given period_end; outputs sampled 1 ns after the edge
   task automatic cyc(input logic pe);
      bus.period_end = pe;
      @(posedge clk);
      #1;
      if (bus.overrun === 1'b1) ov_cnt++;
      if (bus.upd === 1'b1) upd_cnt++;
      if (bus.duty_r > 10'd99 || bus.duty_g > 10'd99 || bus.duty_b > 10'd99 ||
          (non_end(bus.duty_r) + non_end(bus.duty_g) + non_end(bus.duty_b)) > 1)
         viol++;
   endtask

   task automatic run_commits(input int n, input string tag);
      int seen   = 0;
      int budget = n * 10 + 20;
      while (seen < n && budget > 0) begin
         cyc(1'b1);
         if (bus.upd === 1'b1) seen++;
         budget--;
      end
      if (seen < n) chk({tag, " timeout"}, 32'(seen), 32'(n));
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.run        = 1'b0;
      bus.step       = 4'd1;
      bus.period_end = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic chk_duty(input string tag, input int r, input int g, input int b, input int ph);
      chk({tag, " duty_r"}, 32'(bus.duty_r), 32'(r));
      chk({tag, " duty_g"}, 32'(bus.duty_g), 32'(g));
      chk({tag, " duty_b"}, 32'(bus.duty_b), 32'(b));
      chk({tag, " phase"},  32'(bus.phase),  32'(ph));
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // 1: reset values, first commit on first period_end at/after the tick
      rst = 1'b1;
      bus.run = 1'b0;
      bus.step = 4'd1;
      bus.period_end = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_duty("reset", 99, 0, 0, 0);
      chk("reset upd", 32'(bus.upd), 0);
      chk("reset overrun", 32'(bus.overrun), 0);
      rst = 1'b0;
      bus.run = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc((i % 4) == 3);
         if (i == 7 || i == 10) begin
            chk("t1 early upd", 32'(bus.upd), 0);
            chk("t1 early duty_g", 32'(bus.duty_g), 0);
         end
      end
      chk("t1 upd", 32'(bus.upd), 1);
      chk_duty("t1", 99, 1, 0, 0);
      cyc(1'b0);
      chk("t1 upd one-shot", 32'(bus.upd), 0);

      // 2: step 1, full wheel
      do_reset();
      bus.run = 1'b1;
      viol = 0;
      run_commits(98, "t2a");
      chk_duty("t2 c98", 99, 98, 0, 0);
      run_commits(1, "t2b");
      chk_duty("t2 c99", 99, 99, 0, 1);
      run_commits(495, "t2c");
      chk_duty("t2 c594", 99, 0, 0, 0);
      chk("t2 invariant", 32'(viol), 0);

      // 3: step 10 saturates at 99
      do_reset();
      bus.run = 1'b1;
      bus.step = 4'd10;
      for (int k = 1; k <= 9; k++) begin
         run_commits(1, "t3");
         chk("t3 duty_g", 32'(bus.duty_g), 32'(10 * k));
      end
      chk("t3 phase mid", 32'(bus.phase), 0);
      run_commits(1, "t3 c10");
      chk_duty("t3 c10", 99, 99, 0, 1);
      run_commits(1, "t3 c11");
      chk_duty("t3 c11", 89, 99, 0, 1);
      chk("t3 invariant", 32'(viol), 0);

      // 4: no period boundary -> second tick overruns, then one commit
      do_reset();
      bus.run = 1'b1;
      ov_cnt = 0;
      upd_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(1'b0);
         if (i == 19) chk("t4 overrun pulse", 32'(bus.overrun), 1);
         if (i == 20) chk("t4 overrun clear", 32'(bus.overrun), 0);
      end
      chk("t4 overrun count", 32'(ov_cnt), 1);
      chk("t4 no upd", 32'(upd_cnt), 0);
      chk_duty("t4 held", 99, 0, 0, 0);
      cyc(1'b1);
      chk("t4 upd", 32'(bus.upd), 1);
      chk("t4 duty_g", 32'(bus.duty_g), 1);
      cyc(1'b1);
      chk("t4 single commit", 32'(bus.upd), 0);
      chk("t4 duty_g after", 32'(bus.duty_g), 1);

      // 5: coincident tick/period_end, then freeze with a pending update
      do_reset();
      bus.run = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(i == 9);
         if (i == 8) chk("t5 pre upd", 32'(bus.upd), 0);
      end
      chk("t5 coincident upd", 32'(bus.upd), 1);
      chk("t5 coincident duty_g", 32'(bus.duty_g), 1);
      for (int i = 10; i < 24; i++) cyc(1'b0);
      bus.run = 1'b0;
      upd_cnt = 0;
      ov_cnt = 0;
      for (int i = 0; i < 30; i++) cyc(i % 2 == 0);
      chk("t5 frozen upd", 32'(upd_cnt), 0);
      chk("t5 frozen overrun", 32'(ov_cnt), 0);
      chk_duty("t5 frozen", 99, 1, 0, 0);
      bus.run = 1'b1;
      n = 0;
      while (n < 20) begin
         cyc(1'b1);
         n++;
         if (bus.upd === 1'b1) break;
      end
      chk("t5 cycles to commit after resume", 32'(n), 6);
      chk("t5 duty_g after resume", 32'(bus.duty_g), 2);

      // 6: async reset mid-phase 3 with a pending update
      do_reset();
      bus.run = 1'b1;
      bus.step = 4'd15;
      run_commits(21, "t6a");
      chk_duty("t6 phase3 entry", 0, 99, 99, 3);
      run_commits(1, "t6b");
      chk_duty("t6 mid", 0, 84, 99, 3);
      for (int i = 0; i < 10; i++) cyc(1'b0);
      bus.period_end = 1'b1;
      rst = 1'b1;
      #1;
      chk_duty("t6 async rst", 99, 0, 0, 0);
      chk("t6 async rst upd", 32'(bus.upd), 0);
      @(posedge clk);
      #1;
      chk_duty("t6 held rst", 99, 0, 0, 0);
      chk("t6 held rst upd", 32'(bus.upd), 0);
      rst = 1'b0;
      cyc(1'b1);
      chk("t6 pending dropped", 32'(bus.upd), 0);
      chk("t6 duty_g after", 32'(bus.duty_g), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/rgb_fade_sched.md
Name: rgb_fade_sched

Overview:
Scheduler for the RGB PWM duty datapath. It sequences the six-phase hue wheel: red, yellow, green, cyan, blue, magenta, then back to red. Duty changes are paced by a prescaled step tick. A new duty set is committed only at a PWM period boundary, so the PWM generators never see a mid-period duty change. It sits between the clock domain's free-running logic and the three PWM channel generators, and drives their duty inputs.

Parameters:
CLK_FRE, 50_000_000, input clock frequency in Hz
STEP_HZ, 100, hue step rate in Hz; DIV = CLK_FRE/STEP_HZ, elaboration error if DIV < 2
DUTY_W, 10, duty word width
DUTY_MAX, 99, full-on duty value; must be < 2**DUTY_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
run  in  1  1 = sequencing enabled; 0 = freeze
step  in  4  duty increment per update; 0 is treated as 1
period_end  in  1  one-cycle pulse from PWM counter at period wrap
duty_r  out  DUTY_W  committed red duty
duty_g  out  DUTY_W  committed green duty
duty_b  out  DUTY_W  committed blue duty
phase  out  3  current hue phase, 0..5
upd  out  1  one-cycle pulse: duties changed this cycle
overrun  out  1  one-cycle pulse: step tick dropped because an update was already pending

Behaviour:
- Reset (async assert, sync release):
  - duty_r=DUTY_MAX, duty_g=0, duty_b=0
  - phase=0, upd=0, overrun=0
  - prescaler=0, pending=0
- Prescaler:
  - Counts 0..DIV-1 only while run=1.
  - tick is asserted on the cycle the count equals DIV-1; the count wraps to 0 there.
  - run=0: count holds, pending is cleared, outputs hold.
- Pending flag:
  - Set on tick.
  - Cleared on commit.
  - tick while pending=1 and no commit that cycle: pending stays 1 and overrun pulses.
  - tick and period_end in the same cycle: counts as pending, so the commit happens that cycle.
- Commit:
  - Condition: run=1, period_end=1, and (pending=1 or tick=1).
  - The new duties and phase are registered at that edge.
  - upd=1 in the following cycle, aligned with the new values (one-cycle latency).
- Phase table (moving channel, direction):
  - 0 R->Y: G up
  - 1 Y->G: R down
  - 2 G->C: B up
  - 3 C->B: G down
  - 4 B->M: R up
  - 5 M->R: B down
- Arithmetic:
  - s = (step==0) ? 1 : step.
  - Up: next = min(cur+s, DUTY_MAX), computed at DUTY_W+1 bits so there is no wrap.
  - Down: next = (cur<=s) ? 0 : cur-s.
  - Only the moving channel changes.
- Phase advance:
  - Happens in the same commit in which the moving channel reaches its endpoint (DUTY_MAX for up, 0 for down).
  - Phase 5 wraps to 0.
  - The next commit moves the new phase's channel.
- Invariant: exactly one channel is non-endpoint at any time. Duty values never exceed DUTY_MAX.
- Step changes mid-phase take effect at the next commit. No restart occurs.
- Reset mid-phase returns to the reset state immediately, regardless of pending or period_end.

Decomposition:
- Package pwm_rgb_pkg:
  - phase_t enum: PH_RY, PH_YG, PH_GC, PH_CB, PH_BM, PH_MR
  - DUTY_W default
  - function next_phase()
  - function channel/direction lookup
- Sub-module step_prescaler (params CLK_FRE, STEP_HZ; ports clk, rst, en, tick). It is reused by the other LED demos.

Test Plan:
All scenarios use CLK_FRE=1000, STEP_HZ=100, so DIV=10.
1. Reset, then run=1, step=1, period_end every 4 cycles -> first commit at the first period_end at or after cycle 9. The upd pulse follows one cycle after that commit with duty_g=1, duty_r=99, duty_b=0, phase=0.
2. step=1, period_end tied 1 -> phase goes 0->1 on the 99th commit (duty_g=99). A full wheel takes 594 commits and ends back at duties (99,0,0), phase 0.
3. step=10 -> duty_g sequence 10,20,…,90,99. Phase is 1 after the 10th commit, and no value exceeds 99.
4. period_end held 0 for 25 cycles with run=1 -> overrun pulses on the 2nd tick, no upd, duties unchanged. The next period_end gives exactly one commit of +s.
5. tick and period_end coincident -> commit on that edge and upd the next cycle. With run toggled 0 for 30 cycles mid-phase, duties and phase hold, pending clears, and the prescaler count holds.
6. rst asserted mid-phase 3 with a pending commit -> the next cycle shows duties (99,0,0), phase 0, upd 0, even if period_end=1.
